sid_frame_scheduler: RTL and testbench
======================================

// Module: sid_frame_scheduler
// PURPOSE
//  Frame-synchronous register-write scheduler for the 8-bit Wishbone SID slave.
//  Host/SPI side queues (addr,data) pairs; each frame_tick releases one frame
//  (pairs up to and including one tagged sync) as back-to-back single WB writes.
//  Sits between the SPI bridge/player logic and the SID slave; gives jitter-free
//  register updates at the tune's replay rate.
// PARAMETERS
//  DEPTH    16  queue entries, power of 2, >=4
//  TIMEOUT  15  cycles waiting for m_ack before a write is aborted, 1..255
// PORTS
//  clk           in   1  system clock (same clock as the SID slave WB side)
//  rst_n         in   1  asynchronous, active-low reset
//  push_valid    in   1  queue write request
//  push_ready    out  1  queue not full; a push happens when valid&ready
//  push_adr      in   8  SID register address
//  push_dat      in   8  register data
//  push_sync     in   1  entry is the last write of its frame
//  frame_tick    in   1  one-cycle frame strobe (e.g. 50 Hz)
//  m_adr         out  8  WB address
//  m_dat         out  8  WB write data
//  m_cyc, m_stb  out  1  WB cycle/strobe (always asserted together)
//  m_we          out  1  WB write enable (1 whenever m_stb=1)
//  m_ack         in   1  WB acknowledge
//  busy          out  1  state != IDLE
//  frame_count   out  8  frames completed, wraps 255->0
//  underrun      out  1  one-cycle pulse: tick in IDLE with queue empty
//  late          out  1  one-cycle pulse: tick while not IDLE (tick dropped)
//  err_timeout   out  1  sticky; set on any aborted write, cleared by reset only
// BEHAVIOUR
//  Reset: queue emptied, state IDLE, all outputs 0 except push_ready=1.
//   Asserting rst_n low mid-transfer drops m_cyc/m_stb immediately (async).
//  Queue: FIFO of {sync,adr,dat}, 17 bits; count 0..DEPTH; push_ready=count!=DEPTH.
//   Pointers wrap modulo DEPTH. Push and pop in the same cycle are both legal
//   and leave count unchanged.
//  States IDLE, ISSUE, WAIT_ACK, GAP, STALL:
//   IDLE: tick & count==0 -> underrun pulse, stay. tick & count>0 -> ISSUE.
//   ISSUE (1 cycle): pop head into m_adr/m_dat/sync_r; m_cyc=m_stb=m_we<=1
//    (visible next cycle); -> WAIT_ACK.
//   WAIT_ACK: m_ack=1 -> m_cyc/m_stb/m_we<=0 next edge, -> GAP.
//    Timer reaches TIMEOUT with no ack -> same deassert, err_timeout<=1, -> GAP
//    (the write is treated as done and is not retried).
//   GAP (1 cycle, bus idle): sync_r -> frame_count+1, -> IDLE;
//    else count>0 -> ISSUE; else -> STALL.
//   STALL: waits mid-frame for data; count>0 -> ISSUE. Ticks here pulse late.
//  Any tick outside IDLE: late pulse; tick is discarded, not queued.
//  m_adr/m_dat hold their value after a write; only meaningful when m_stb=1.
//  Timing with a 1-cycle-ack slave: tick at cycle T -> m_stb rises T+2, ack
//   T+3, m_stb falls T+4; the next write's m_stb rises T+6 (4 cycles/write).
//   m_stb never stays high in the cycle after an ack (no spurious second cs).
//  The timer counts only in WAIT_ACK and is cleared on entry to WAIT_ACK.
// TESTING
//  Push 3 entries (0x00/0x11, 0x01/0x22, 0x04/0x41 sync), tick -> exactly 3 WB
//   writes in order, 4 cycles apart, frame_count=1, busy low afterwards.
//  Tick with empty queue -> underrun=1 for 1 cycle, no m_stb, frame_count unchanged.
//  Push 2 non-sync entries, tick, push sync entry 20 cycles later -> STALL held,
//   3rd write issues after the push, frame_count=1.
//  Slave never acks -> m_stb high for exactly TIMEOUT cycles, err_timeout=1,
//   next entry still issued.
//  Fill DEPTH entries -> push_ready=0; push_valid held high gets no extra entry
//   in; tick during the drain -> late pulse; the wrapped pointers deliver order.
//  Assert rst_n low during WAIT_ACK -> m_stb=0 at once; after release queue
//   empty, push_ready=1, frame_count=0.

Source files
------------

// File: rtl/sid_frame_scheduler.sv
// sid_frame_scheduler: queues SID register writes from the host/SPI side and
// releases one frame of them (up to and including a sync-tagged entry) as
// back-to-back single Wishbone writes on every frame_tick.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for frame_tick; tick with empty queue = underrun
// ISSUE    | pop queue head onto the bus registers, raise cyc/stb/we
// WAIT_ACK | bus cycle open; close on m_ack or ack-timer terminal count
// GAP      | one idle bus cycle; end frame on sync, else next entry
// STALL    | mid-frame, queue empty; wait for the rest of the frame
module sid_frame_scheduler #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_valid,
   output logic       push_ready,
   input  logic [7:0] push_adr,
   input  logic [7:0] push_dat,
   input  logic       push_sync,
   input  logic       frame_tick,
   output logic [7:0] m_adr,
   output logic [7:0] m_dat,
   output logic       m_cyc,
   output logic       m_stb,
   output logic       m_we,
   input  logic       m_ack,
   output logic       busy,
   output logic [7:0] frame_count,
   output logic       underrun,
   output logic       late,
   output logic       err_timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   // the ack timer is a down-counter: loaded with TIMEOUT-1 so that the
   // terminal count of zero is reached in the TIMEOUT-th WAIT_ACK cycle
   localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, GAP, STALL} state_t;

   state_t        state;
   logic [16:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [16:0]   head;
   logic          do_push;
   logic          do_pop;
   logic          sync_r;
   logic [7:0]    timer;

   assign push_ready = (count != FULL);
   assign do_push    = push_valid & push_ready;
   assign do_pop     = (state == ISSUE);
   assign head       = mem[rd_ptr];
   assign busy       = (state != IDLE);

   // queue storage, {sync, adr, dat}
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {push_sync, push_adr, push_dat};
   end

   // queue pointers and occupancy; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // frame sequencer with registered bus outputs and status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         m_adr       <= '0;
         m_dat       <= '0;
         m_cyc       <= 1'b0;
         m_stb       <= 1'b0;
         m_we        <= 1'b0;
         sync_r      <= 1'b0;
         timer       <= '0;
         frame_count <= '0;
         underrun    <= 1'b0;
         late        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         underrun <= 1'b0;
         late     <= 1'b0;
         if (frame_tick && state != IDLE) late <= 1'b1;
         case (state)
            IDLE: begin
               if (frame_tick) begin
                  if (count == '0) underrun <= 1'b1;
                  else             state    <= ISSUE;
               end
            end
            ISSUE: begin
               {sync_r, m_adr, m_dat} <= head;
               m_cyc <= 1'b1;
               m_stb <= 1'b1;
               m_we  <= 1'b1;
               timer <= TMO_LOAD;
               state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               // an ack arriving on the terminal-count cycle still counts as success
               if (m_ack || timer == '0) begin
                  m_cyc <= 1'b0;
                  m_stb <= 1'b0;
                  m_we  <= 1'b0;
                  if (!m_ack) err_timeout <= 1'b1;
                  state <= GAP;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            GAP: begin
               if (sync_r) begin
                  frame_count <= frame_count + 1'b1;
                  state       <= IDLE;
               end else if (count != '0) begin
                  state <= ISSUE;
               end else begin
                  state <= STALL;
               end
            end
            STALL: begin
               if (count != '0) state <= ISSUE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sid_frame_scheduler.sv
// Directed bench for sid_frame_scheduler: a scoreboard queue holds the
// expected (adr,dat) of every accepted push and is popped on each m_stb rise.
module tb_sid_frame_scheduler;

   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 15;

   logic       clk;
   logic       rst_n;
   logic       push_valid;
   logic       push_ready;
   logic [7:0] push_adr;
   logic [7:0] push_dat;
   logic       push_sync;
   logic       frame_tick;
   logic [7:0] m_adr;
   logic [7:0] m_dat;
   logic       m_cyc;
   logic       m_stb;
   logic       m_we;
   logic       m_ack;
   logic       busy;
   logic [7:0] frame_count;
   logic       underrun;
   logic       late;
   logic       err_timeout;

   sid_frame_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_valid  (push_valid),
      .push_ready  (push_ready),
      .push_adr    (push_adr),
      .push_dat    (push_dat),
      .push_sync   (push_sync),
      .frame_tick  (frame_tick),
      .m_adr       (m_adr),
      .m_dat       (m_dat),
      .m_cyc       (m_cyc),
      .m_stb       (m_stb),
      .m_we        (m_we),
      .m_ack       (m_ack),
      .busy        (busy),
      .frame_count (frame_count),
      .underrun    (underrun),
      .late        (late),
      .err_timeout (err_timeout)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [15:0] exp_q [$];
   int          rise_log [$];
   int          wr_count   = 0;
   int          fall_count = 0;
   int          last_len   = 0;
   int          rise_cyc   = 0;
   int          stb_age    = 0;
   logic        stb_prev   = 1'b0;
   logic        ack_en     = 1'b1;
   int          tick_cyc   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // slave model (ack in the cycle after stb rises) plus write monitor
   always @(negedge clk) begin
      logic [15:0] e;
      if (m_stb) stb_age++;
      else       stb_age = 0;
      m_ack = ack_en && (stb_age == 2);
      if (m_stb && !stb_prev) begin
         wr_count++;
         rise_cyc = cyc;
         rise_log.push_back(cyc);
         check("wr_we_cyc", {30'd0, m_we, m_cyc}, 32'd3);
         if (exp_q.size() == 0) begin
            check("wr_unexpected", {16'd0, m_adr, m_dat}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("wr_adr_dat", {16'd0, m_adr, m_dat}, {16'd0, e});
         end
      end
      if (!m_stb && stb_prev) begin
         fall_count++;
         last_len = cyc - rise_cyc;
      end
      stb_prev = m_stb;
   end

   task automatic push(input logic [7:0] a, input logic [7:0] d, input logic s);
      push_valid = 1'b1;
      push_adr   = a;
      push_dat   = d;
      push_sync  = s;
      if (push_ready) exp_q.push_back({a, d});
      @(negedge clk);
      push_valid = 1'b0;
   endtask

   task automatic tick(output logic u, output logic l);
      frame_tick = 1'b1;
      tick_cyc   = cyc;
      @(negedge clk);
      frame_tick = 1'b0;
      u = underrun;
      l = late;
   endtask

   task automatic wait_idle(input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy && !m_stb && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("wait_idle_in_budget", {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_fall(input int f0, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (fall_count > f0) begin
            ok = 1'b1;
            break;
         end
      end
      check("wait_fall_in_budget", {31'd0, ok}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
      $fatal(1, "watchdog");
   end

   initial begin
      logic u, l;
      int   n0, f0;
      int   exp_fc = 0;

      rst_n      = 1'b0;
      push_valid = 1'b0;
      push_adr   = '0;
      push_dat   = '0;
      push_sync  = 1'b0;
      frame_tick = 1'b0;
      m_ack      = 1'b0;
      repeat (3) @(negedge clk);

      // reset values
      check("rst_push_ready", {31'd0, push_ready}, 32'd1);
      check("rst_bus", {29'd0, m_cyc, m_stb, m_we}, 32'd0);
      check("rst_status", {28'd0, busy, underrun, late, err_timeout}, 32'd0);
      check("rst_frame_count", {24'd0, frame_count}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // one frame of three writes with a 1-cycle-ack slave
      rise_log.delete();
      n0 = wr_count;
      push(8'h00, 8'h11, 1'b0);
      push(8'h01, 8'h22, 1'b0);
      push(8'h04, 8'h41, 1'b1);
      tick(u, l);
      check("t1_no_underrun", {30'd0, u, l}, 32'd0);
      wait_idle(100);
      exp_fc++;
      check("t1_writes", wr_count - n0, 32'd3);
      check("t1_latency", rise_log[0] - tick_cyc, 32'd2);
      check("t1_spacing_a", rise_log[1] - rise_log[0], 32'd4);
      check("t1_spacing_b", rise_log[2] - rise_log[1], 32'd4);
      check("t1_stb_len", last_len, 32'd2);
      check("t1_frame_count", {24'd0, frame_count}, exp_fc);
      check("t1_busy", {31'd0, busy}, 32'd0);

      // tick with an empty queue
      n0 = wr_count;
      tick(u, l);
      check("t2_underrun_pulse", {31'd0, u}, 32'd1);
      @(negedge clk);
      check("t2_underrun_clear", {31'd0, underrun}, 32'd0);
      repeat (5) @(negedge clk);
      check("t2_no_write", wr_count - n0, 32'd0);
      check("t2_frame_count", {24'd0, frame_count}, exp_fc);

      // frame that stalls mid-way waiting for its sync entry
      n0 = wr_count;
      push(8'h05, 8'h10, 1'b0);
      push(8'h06, 8'h20, 1'b0);
      tick(u, l);
      repeat (20) @(negedge clk);
      check("t3_stall_busy", {31'd0, busy}, 32'd1);
      check("t3_stall_writes", wr_count - n0, 32'd2);
      check("t3_stall_stb", {31'd0, m_stb}, 32'd0);
      tick(u, l);
      check("t3_late_in_stall", {30'd0, u, l}, 32'd1);
      push(8'h18, 8'h0F, 1'b1);
      wait_idle(100);
      exp_fc++;
      check("t3_writes", wr_count - n0, 32'd3);
      check("t3_frame_count", {24'd0, frame_count}, exp_fc);

      // slave that never acks the first write
      ack_en = 1'b0;
      n0 = wr_count;
      f0 = fall_count;
      push(8'h10, 8'hAA, 1'b0);
      push(8'h11, 8'hBB, 1'b1);
      tick(u, l);
      wait_fall(f0, 100);
      check("t4_stb_len_timeout", last_len, TIMEOUT);
      check("t4_err_timeout", {31'd0, err_timeout}, 32'd1);
      ack_en = 1'b1;
      wait_idle(100);
      exp_fc++;
      check("t4_writes", wr_count - n0, 32'd2);
      check("t4_stb_len_acked", last_len, 32'd2);
      check("t4_frame_count", {24'd0, frame_count}, exp_fc);
      check("t4_err_sticky", {31'd0, err_timeout}, 32'd1);

      // fill the queue, try to overfill, drain across the pointer wrap
      n0 = wr_count;
      for (int i = 0; i < DEPTH; i++)
         push(8'(8'h20 + i), 8'(8'hC0 ^ (i * 7)), (i == DEPTH - 1));
      check("t5_full_ready", {31'd0, push_ready}, 32'd0);
      push_valid = 1'b1;
      push_adr   = 8'hEE;
      push_dat   = 8'hEE;
      push_sync  = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t5_full_hold", {31'd0, push_ready}, 32'd0);
      end
      push_valid = 1'b0;
      tick(u, l);
      repeat (6) @(negedge clk);
      tick(u, l);
      check("t5_late_in_drain", {30'd0, u, l}, 32'd1);
      @(negedge clk);
      check("t5_late_clear", {31'd0, late}, 32'd0);
      wait_idle(300);
      exp_fc++;
      check("t5_writes", wr_count - n0, DEPTH);
      check("t5_frame_count", {24'd0, frame_count}, exp_fc);
      check("t5_ready_after", {31'd0, push_ready}, 32'd1);

      // asynchronous reset while a write waits for its ack
      ack_en = 1'b0;
      f0 = fall_count;
      n0 = wr_count;
      push(8'h30, 8'h01, 1'b0);
      push(8'h31, 8'h02, 1'b1);
      tick(u, l);
      @(negedge clk);
      repeat (3) @(negedge clk);
      check("t6_stb_before_rst", {31'd0, m_stb}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_stb_async_drop", {30'd0, m_cyc, m_stb}, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      ack_en = 1'b1;
      @(negedge clk);
      check("t6_ready", {31'd0, push_ready}, 32'd1);
      check("t6_frame_count", {24'd0, frame_count}, 32'd0);
      check("t6_status", {29'd0, busy, err_timeout, m_stb}, 32'd0);
      n0 = wr_count;
      tick(u, l);
      check("t6_empty_underrun", {31'd0, u}, 32'd1);
      repeat (5) @(negedge clk);
      check("t6_no_write", wr_count - n0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
